// File: rtl/sap_u_pkg.sv
// Shared constants for the SAP-U microcode sequencer: opcodes, control-word bit map and mode encoding.
package sap_u_pkg;

  localparam int CTRL_W = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CTRL_HALT         = 0;
  localparam int CTRL_MAR_LOAD     = 1;
  localparam int CTRL_RAM_LOAD     = 2;
  localparam int CTRL_RAM_OUT      = 3;
  localparam int CTRL_IR_LOAD      = 4;
  localparam int CTRL_IR_OUT       = 5;
  localparam int CTRL_REG_A_LOAD   = 6;
  localparam int CTRL_REG_A_ENABLE = 7;
  localparam int CTRL_ALU_ENABLE   = 8;
  localparam int CTRL_SUBTRACT     = 9;
  localparam int CTRL_REG_B_LOAD   = 10;
  localparam int CTRL_OUT_LOAD     = 11;
  localparam int CTRL_PC_INC       = 12;
  localparam int CTRL_PC_OUT       = 13;
  localparam int CTRL_JUMP         = 14;
  localparam int CTRL_FLAGS_LOAD   = 15;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer bundle: run/opcode/flags in from the datapath, control word, step and halted out.
interface control_sequencer_if #(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
);
  import sap_u_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                flag_c;
  logic                flag_z;
  logic [CTRL_W-1:0]   ctrl;
  logic [STEP_W-1:0]   step;
  logic                halted;

  modport master (
    output run, opcode, flag_c, flag_z,
    input  ctrl, step, halted
  );

  modport slave (
    input  run, opcode, flag_c, flag_z,
    output ctrl, step, halted
  );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and last-step marker.
// SEQ_COND_JUMP_EN adds JC/JZ and the flags_load strobe in the ALU step.
module microcode_rom
  import sap_u_pkg::*;
#(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [STEP_W-1:0]   step_i,
  input  logic                flag_c_i,
  input  logic                flag_z_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                last_o
);

  always_comb begin
    ctrl_o = '0;
    last_o = 1'b0;
    case (step_i)
      STEP_W'(0): begin
        ctrl_o[CTRL_PC_OUT]   = 1'b1;
        ctrl_o[CTRL_MAR_LOAD] = 1'b1;
      end
      STEP_W'(1): begin
        ctrl_o[CTRL_RAM_OUT] = 1'b1;
        ctrl_o[CTRL_IR_LOAD] = 1'b1;
        ctrl_o[CTRL_PC_INC]  = 1'b1;
      end
      default: begin
        // Any execute step not claimed below ends the instruction, so a stray step always recovers to T0.
        last_o = 1'b1;
        case (opcode_i)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
            if (step_i == STEP_W'(2)) begin
              ctrl_o[CTRL_IR_OUT]   = 1'b1;
              ctrl_o[CTRL_MAR_LOAD] = 1'b1;
              last_o                = 1'b0;
            end else if (step_i == STEP_W'(3)) begin
              case (opcode_i)
                OP_LDA: begin
                  ctrl_o[CTRL_RAM_OUT]    = 1'b1;
                  ctrl_o[CTRL_REG_A_LOAD] = 1'b1;
                end
                OP_STA: begin
                  ctrl_o[CTRL_REG_A_ENABLE] = 1'b1;
                  ctrl_o[CTRL_RAM_LOAD]     = 1'b1;
                end
                default: begin
                  ctrl_o[CTRL_RAM_OUT]    = 1'b1;
                  ctrl_o[CTRL_REG_B_LOAD] = 1'b1;
                  last_o                  = 1'b0;
                end
              endcase
            end else if (step_i == STEP_W'(4) && (opcode_i == OP_ADD || opcode_i == OP_SUB)) begin
              ctrl_o[CTRL_ALU_ENABLE] = 1'b1;
              ctrl_o[CTRL_REG_A_LOAD] = 1'b1;
              ctrl_o[CTRL_SUBTRACT]   = (opcode_i == OP_SUB);
`ifdef SEQ_COND_JUMP_EN
              ctrl_o[CTRL_FLAGS_LOAD] = 1'b1;
`endif
            end
          end
          OP_LDI: begin
            if (step_i == STEP_W'(2)) begin
              ctrl_o[CTRL_IR_OUT]     = 1'b1;
              ctrl_o[CTRL_REG_A_LOAD] = 1'b1;
            end
          end
          OP_JMP: begin
            if (step_i == STEP_W'(2)) begin
              ctrl_o[CTRL_IR_OUT] = 1'b1;
              ctrl_o[CTRL_JUMP]   = 1'b1;
            end
          end
`ifdef SEQ_COND_JUMP_EN
          OP_JC: begin
            if (step_i == STEP_W'(2) && flag_c_i) begin
              ctrl_o[CTRL_IR_OUT] = 1'b1;
              ctrl_o[CTRL_JUMP]   = 1'b1;
            end
          end
          OP_JZ: begin
            if (step_i == STEP_W'(2) && flag_z_i) begin
              ctrl_o[CTRL_IR_OUT] = 1'b1;
              ctrl_o[CTRL_JUMP]   = 1'b1;
            end
          end
`endif
          OP_OUT: begin
            if (step_i == STEP_W'(2)) begin
              ctrl_o[CTRL_REG_A_ENABLE] = 1'b1;
              ctrl_o[CTRL_OUT_LOAD]     = 1'b1;
            end
          end
          OP_HLT: begin
            if (step_i == STEP_W'(2)) ctrl_o[CTRL_HALT] = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

`ifndef SEQ_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_c_i ^ flag_z_i;
`endif

endmodule

// File: rtl/control_sequencer.sv
// SAP-U T-state sequencer: step counter with run gating, sticky halt, microcode decode.
// Build with SEQ_COND_JUMP_EN for JC/JZ and flags_load.
//   state     | meaning
//   MODE_RUN  | stepping through T-states while run=1
//   MODE_HALT | HLT executed; step frozen at 0, ctrl = halt only, left only by reset
module control_sequencer
  import sap_u_pkg::*;
#(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  control_sequencer_if.slave bus
);

  logic [STEP_W-1:0] step_q, step_d;
  seq_mode_e         mode_q, mode_d;
  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;

  microcode_rom #(
    .STEP_W   (STEP_W),
    .OPCODE_W (OPCODE_W)
  ) u_rom (
    .opcode_i (bus.opcode),
    .step_i   (step_q),
    .flag_c_i (bus.flag_c),
    .flag_z_i (bus.flag_z),
    .ctrl_o   (rom_ctrl),
    .last_o   (rom_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      mode_q <= MODE_RUN;
    end else begin
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    step_d = step_q;
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN: begin
        if (bus.run) begin
          step_d = rom_last ? '0 : step_q + STEP_W'(1);
          if (rom_ctrl[CTRL_HALT]) mode_d = MODE_HALT;
        end
      end
      MODE_HALT: step_d = '0;
      default:   mode_d = MODE_RUN;
    endcase
  end

  // Reset forces a clean zero word so no strobe survives an aborted instruction.
  always_comb begin
    bus.ctrl = '0;
    if (reset) begin
      if (mode_q == MODE_HALT) bus.ctrl[CTRL_HALT] = 1'b1;
      else                     bus.ctrl = rom_ctrl;
    end
  end

  assign bus.step   = step_q;
  assign bus.halted = (mode_q == MODE_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute words, run gating, halt and async reset.
module tb_control_sequencer;
  import sap_u_pkg::*;

`ifdef SEQ_COND_JUMP_EN
  localparam logic [15:0] EXP_ADD_T4 = 16'h8140;
  localparam logic [15:0] EXP_SUB_T4 = 16'h8340;
  localparam logic [15:0] EXP_JZ1_T2 = 16'h4020;
`else
  localparam logic [15:0] EXP_ADD_T4 = 16'h0140;
  localparam logic [15:0] EXP_SUB_T4 = 16'h0340;
  localparam logic [15:0] EXP_JZ1_T2 = 16'h0000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  control_sequencer_if #(.STEP_W(3), .OPCODE_W(4)) bus ();

  control_sequencer #(.STEP_W(3), .OPCODE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st, input logic [15:0] cw, input logic h);
    chk({tag, ".step"}, {13'd0, bus.step}, {13'd0, st});
    chk({tag, ".ctrl"}, bus.ctrl, cw);
    chk({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, h});
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.opcode = OP_ADD;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
    #1;
    chk_state("in_reset", 3'd0, 16'h0000, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_state("post_reset_T0", 3'd0, 16'h2002, 1'b0);

    // ADD: 0,1,2,3,4 then straight into the next T0
    bus.run = 1'b1;
    tick(); chk_state("add_T1", 3'd1, 16'h1018, 1'b0);
    tick(); chk_state("add_T2", 3'd2, 16'h0022, 1'b0);
    tick(); chk_state("add_T3", 3'd3, 16'h0408, 1'b0);
    tick(); chk_state("add_T4", 3'd4, EXP_ADD_T4, 1'b0);
    tick(); chk_state("add_wrap", 3'd0, 16'h2002, 1'b0);

    // asynchronous reset in the middle of ADD T3
    tick(); tick(); tick();
    chk_state("add2_T3", 3'd3, 16'h0408, 1'b0);
    #2 reset = 1'b0;
    #1 chk_state("async_reset", 3'd0, 16'h0000, 1'b0);
    tick();
    reset = 1'b1;
    #1 chk_state("rst_release_T0", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_SUB;
    tick(); tick(); tick(); tick();
    chk_state("sub_T4", 3'd4, EXP_SUB_T4, 1'b0);
    tick(); chk_state("sub_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_LDI;
    tick(); tick();
    chk_state("ldi_T2", 3'd2, 16'h0060, 1'b0);
    tick(); chk_state("ldi_wrap", 3'd0, 16'h2002, 1'b0);

    // LDA with run 1,0,0,1: step and strobes held for two cycles
    bus.opcode = OP_LDA;
    tick(); tick();
    chk_state("lda_T2", 3'd2, 16'h0022, 1'b0);
    bus.run = 1'b0;
    tick(); chk_state("lda_hold1", 3'd2, 16'h0022, 1'b0);
    tick(); chk_state("lda_hold2", 3'd2, 16'h0022, 1'b0);
    bus.run = 1'b1;
    tick(); chk_state("lda_T3", 3'd3, 16'h0048, 1'b0);
    tick(); chk_state("lda_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_STA;
    tick(); tick(); tick();
    chk_state("sta_T3", 3'd3, 16'h0084, 1'b0);
    tick(); chk_state("sta_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_JMP;
    tick(); tick();
    chk_state("jmp_T2", 3'd2, 16'h4020, 1'b0);
    tick(); chk_state("jmp_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_OUT;
    tick(); tick();
    chk_state("out_T2", 3'd2, 16'h0880, 1'b0);
    tick(); chk_state("out_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = 4'b1010;
    tick(); tick();
    chk_state("undef_T2", 3'd2, 16'h0000, 1'b0);
    tick(); chk_state("undef_wrap", 3'd0, 16'h2002, 1'b0);

    bus.opcode = OP_JZ;
    bus.flag_z = 1'b1;
    tick(); tick();
    chk_state("jz1_T2", 3'd2, EXP_JZ1_T2, 1'b0);
    tick(); chk_state("jz1_wrap", 3'd0, 16'h2002, 1'b0);
    bus.flag_z = 1'b0;
    tick(); tick();
    chk_state("jz0_T2", 3'd2, 16'h0000, 1'b0);
    tick(); chk_state("jz0_wrap", 3'd0, 16'h2002, 1'b0);

    // HLT decoded with run=0 must not halt until run returns
    bus.opcode = OP_HLT;
    tick(); tick();
    chk_state("hlt_T2", 3'd2, 16'h0001, 1'b0);
    bus.run = 1'b0;
    tick(); chk_state("hlt_paused", 3'd2, 16'h0001, 1'b0);
    bus.run = 1'b1;
    tick(); chk_state("halted", 3'd0, 16'h0001, 1'b1);
    bus.opcode = OP_ADD;
    tick(); chk_state("halted_run1", 3'd0, 16'h0001, 1'b1);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    tick(); tick();
    chk_state("halted_pulse", 3'd0, 16'h0001, 1'b1);

    #2 reset = 1'b0;
    #1 chk_state("halt_reset", 3'd0, 16'h0000, 1'b0);
    tick();
    reset = 1'b1;
    #1 chk_state("halt_release", 3'd0, 16'h2002, 1'b0);
    tick(); chk_state("resume_T1", 3'd1, 16'h1018, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
